// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum, oversample ratio and timer widths.
// Used by both the transmit serializer and the receive side.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int OVERSAMPLE = 8;
  localparam int PRESCALE_W = 16;
  localparam int TIMER_W    = PRESCALE_W + 3;
  localparam int BIT_CNT_W  = 4;

  // A prescale of zero would give a zero-length bit; treat it as one.
  function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
    return (p == '0) ? PRESCALE_W'(1) : p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load 8*P-1, count to zero, flag the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  bit_done,
  output logic                  bit_almost_done
);

  logic [TIMER_W-1:0] count_q;
  logic               running_q;
  logic [TIMER_W-1:0] load_value;

  assign load_value = TIMER_W'(period) * TIMER_W'(OVERSAMPLE) - TIMER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (load) begin
      count_q   <= load_value;
      running_q <= 1'b1;
    end else if (running_q) begin
      if (count_q == '0) begin
        running_q <= 1'b0;
      end else begin
        count_q <= count_q - TIMER_W'(1);
      end
    end
  end

  assign bit_done        = running_q && (count_q == '0);
  assign bit_almost_done = running_q && (count_q == TIMER_W'(1));

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: AXI-Stream byte in, 8N1-style frame out on txd, all outputs registered.
//
// state | meaning
// IDLE  | line high, tready asserted, waiting for a byte
// START | start bit (txd low) for one bit period
// DATA  | data bits LSB-first, bit_cnt selects the bit index
// STOP  | stop bit(s) high; bit_cnt reused as stop-bit index
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [PRESCALE_W-1:0] prescale
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic                  txd_q, txd_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;

  logic                  handshake;
  logic                  bit_done;
  logic                  bit_almost_done;
  logic                  timer_load;
  logic [PRESCALE_W-1:0] timer_period;

  assign handshake = s_axis_tvalid && tready_q;

  // The period used for the first bit comes straight from the port; later bits use the latched copy.
  assign timer_load   = handshake || (bit_done && (state_d != IDLE));
  assign timer_period = handshake ? eff_prescale(prescale) : period_q;

  uart_bit_timer u_bit_timer (
    .clk             (clk),
    .rst             (rst),
    .load            (timer_load),
    .period          (timer_period),
    .bit_done        (bit_done),
    .bit_almost_done (bit_almost_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      period_q  <= '0;
      txd_q     <= 1'b1;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      period_q  <= period_d;
      txd_q     <= txd_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_cnt_q == LAST_DATA_BIT)) state_d = STOP;
      STOP:    if (bit_done && (bit_cnt_q == LAST_STOP_BIT)) state_d = handshake ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    period_d  = period_q;
    if (handshake) begin
      shreg_d   = s_axis_tdata;
      bit_cnt_d = '0;
      period_d  = eff_prescale(prescale);
    end else if (bit_done) begin
      case (state_q)
        DATA: begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = (bit_cnt_q == LAST_DATA_BIT) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        end
        STOP:    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        default: bit_cnt_d = '0;
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with it after the register.
  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d   = (state_d != IDLE);
    tready_d = (state_d == IDLE) ||
               ((state_q == STOP) && (bit_cnt_q == LAST_STOP_BIT) && bit_almost_done);
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected per-cycle line state queued at each handshake.
module tb_uart_tx_serializer;

  typedef struct packed {
    logic txd;
    logic busy;
    logic tready;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  tdata0;
  logic        tvalid0, tready0, txd0, busy0;
  logic [15:0] prescale0;
  logic [6:0]  tdata1;
  logic        tvalid1, tready1, txd1, busy1;
  logic [15:0] prescale1;

  uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata0),
    .s_axis_tvalid (tvalid0),
    .s_axis_tready (tready0),
    .txd           (txd0),
    .busy          (busy0),
    .prescale      (prescale0)
  );

  uart_tx_serializer #(.DATA_WIDTH(7), .STOP_BITS(2)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata1),
    .s_axis_tvalid (tvalid1),
    .s_axis_tready (tready1),
    .txd           (txd1),
    .busy          (busy1),
    .prescale      (prescale1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input int which, input logic [8:0] d, input logic [15:0] ps,
                            input int dw, input int sb);
    int   p;
    int   len;
    exp_t e;
    p   = (ps == 16'd0) ? 1 : int'(ps);
    len = 8 * p;
    for (int b = 0; b < 1 + dw + sb; b++) begin
      for (int c = 0; c < len; c++) begin
        e.txd    = (b == 0) ? 1'b0 : ((b <= dw) ? d[b-1] : 1'b1);
        e.busy   = 1'b1;
        e.tready = (b == dw + sb) && (c == len - 1);
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic monitor(input int which);
    exp_t e;
    logic t, b, r;
    bit   have;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (which == 0) begin t = txd0; b = busy0; r = tready0; have = (q0.size() > 0); end
        else begin t = txd1; b = busy1; r = tready1; have = (q1.size() > 0); end
        if (have) begin
          if (which == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check($sformatf("frame%0d_txd", which), t, e.txd);
          check($sformatf("frame%0d_busy", which), b, e.busy);
          check($sformatf("frame%0d_tready", which), r, e.tready);
        end else begin
          check($sformatf("idle%0d_txd", which), t, 1'b1);
          check($sformatf("idle%0d_busy", which), b, 1'b0);
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int which, input logic [8:0] d, input logic [15:0] ps, input bit keep);
    int n;
    n = 0;
    if (which == 0) begin tdata0 = d[7:0]; tvalid0 = 1'b1; prescale0 = ps; end
    else begin tdata1 = d[6:0]; tvalid1 = 1'b1; prescale1 = ps; end
    while ((((which == 0) ? tready0 : tready1) !== 1'b1) && (n < 5000)) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", logic'(n < 5000), 1'b1);
    if (n < 5000) begin
      @(posedge clk);
      if (which == 0) push_frame(0, d, ps, 8, 1);
      else push_frame(1, d, ps, 7, 2);
      @(negedge clk);
    end
    if (!keep) begin
      if (which == 0) tvalid0 = 1'b0;
      else tvalid1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain", logic'(n < 20000), 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    tdata0    = '0;
    tvalid0   = 1'b0;
    prescale0 = 16'd2;
    tdata1    = '0;
    tvalid1   = 1'b0;
    prescale1 = 16'd1;
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(negedge clk);
    check("reset_txd", txd0, 1'b1);
    check("reset_busy", busy0, 1'b0);
    check("reset_tready", tready0, 1'b0);
    check("reset_tready1", tready1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_reset", tready0, 1'b1);
    mon_en = 1'b1;

    // Basic frame, 16-cycle bits
    send(0, 9'h055, 16'd2, 1'b0);
    drain();

    // Back-to-back with tvalid held high
    send(0, 9'h0A5, 16'd1, 1'b1);
    send(0, 9'h03C, 16'd1, 1'b0);
    drain();

    // Hold-off: tdata changes while tready is low
    send(0, 9'h055, 16'd2, 1'b0);
    tdata0  = 8'hFF;
    tvalid0 = 1'b1;
    repeat (60) @(negedge clk);
    check("holdoff_tready", tready0, 1'b0);
    send(0, 9'h000, 16'd2, 1'b0);
    drain();

    // Reset at cycle 40 of a frame
    send(0, 9'h000, 16'd1, 1'b0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("midrst_txd", txd0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_tready", tready0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tready_rise", tready0, 1'b1);
    repeat (100) @(negedge clk);

    // Reset and handshake on the same edge: byte must be dropped
    tdata0  = 8'h0F;
    tvalid0 = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    tvalid0 = 1'b0;
    check("rst_hs_tready", tready0, 1'b0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // prescale 0 behaves as 1
    send(0, 9'h081, 16'd0, 1'b0);
    drain();

    // prescale change mid-frame takes effect only at the next handshake
    send(0, 9'h0C3, 16'd4, 1'b0);
    repeat (50) @(negedge clk);
    send(0, 9'h05A, 16'd1, 1'b0);
    drain();

    // 7 data bits, 2 stop bits
    send(1, 9'h041, 16'd1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
